food_spawner: RTL and testbench
===============================

// Module: food_spawner
// PURPOSE
//  Consumer of the horizontal/vertical pseudo-random generators: steps both on demand and picks a free food cell.
//  - Draws an (x,y) candidate and rejects it if out of grid range or occupied by the snake body.
//  - Falls back to a deterministic linear scan after MAX_TRIES rejections.
//  - Sits between the game FSM (request/done) and the snake occupancy lookup.
// PARAMETERS
//  GRID_W     40  playable columns; 1 <= GRID_W <= 2**XW
//  GRID_H     30  playable rows;    1 <= GRID_H <= 2**YW
//  XW         6   column coordinate width, <= 8
//  YW         5   row coordinate width, <= 8
//  MAX_TRIES  16  random rejections allowed before scan fallback, >= 1
// PORTS
//  CLK         in   1   clock
//  RESET       in   1   asynchronous, active-high reset
//  SPAWN_REQ   in   1   start a spawn; sampled only in IDLE
//  FOOD_EATEN  in   1   clears FOOD_VALID
//  RND_X       in   8   horizontal generator value (registered at source)
//  RND_Y       in   8   vertical generator value (registered at source)
//  RND_CE      out  1   one-cycle step enable to both generators
//  OCC_QUERY   out  1   occupancy lookup strobe
//  OCC_X       out  XW  queried column
//  OCC_Y       out  YW  queried row
//  OCC_HIT     in   1   cell occupied; valid exactly 1 cycle after OCC_QUERY
//  FOOD_X      out  XW  placed food column
//  FOOD_Y      out  YW  placed food row
//  FOOD_VALID  out  1   FOOD_X/FOOD_Y hold a live food cell
//  BUSY        out  1   spawn in progress (state != IDLE)
//  SPAWN_DONE  out  1   one-cycle pulse: food placed
//  SPAWN_FAIL  out  1   one-cycle pulse: board full, no food placed
// BEHAVIOUR
//  - Reset, asynchronous: all outputs 0 and state IDLE, including mid-spawn; RND_CE drops immediately; try/scan counters cleared.
//  - States: IDLE, ADVANCE, SAMPLE, QUERY, WAIT, SCAN_Q, SCAN_W.
//  - IDLE + SPAWN_REQ -> ADVANCE. FOOD_VALID is cleared on the same edge, and tries is cleared.
//  - ADVANCE: RND_CE=1 for exactly this cycle -> SAMPLE.
//  - SAMPLE: cx=RND_X[XW-1:0], cy=RND_Y[YW-1:0].
//    - cx>=GRID_W or cy>=GRID_H: reject.
//    - Otherwise latch (cx,cy) as the candidate, set have_cand=1 -> QUERY.
//  - QUERY: OCC_QUERY=1 with OCC_X/OCC_Y = candidate -> WAIT.
//  - WAIT: OCC_HIT=0 -> accept; OCC_HIT=1 -> reject.
//  - Reject: tries+1.
//    - tries+1 < MAX_TRIES -> ADVANCE.
//    - Otherwise -> SCAN_Q; scan origin = last candidate if have_cand, else (0,0); cells_checked=0.
//  - SCAN_Q: query scan cell -> SCAN_W.
//  - SCAN_W: OCC_HIT=0 -> accept the scan cell.
//    - On a hit: advance cell (x+1; at x==GRID_W-1 -> x=0, y+1; at y==GRID_H-1 -> y=0) and cells_checked+1.
//    - cells_checked reaching GRID_W*GRID_H -> fail; else -> SCAN_Q.
//  - Accept: FOOD_X/FOOD_Y <= cell, FOOD_VALID<=1, SPAWN_DONE<=1 for 1 cycle -> IDLE.
//  - Fail: SPAWN_FAIL<=1 for 1 cycle; FOOD_VALID stays 0; FOOD_X/FOOD_Y unchanged -> IDLE.
//  - Latency, best case: SPAWN_REQ sampled at edge 0 -> SPAWN_DONE high after edge 4.
//    - Each range rejection costs +2 cycles; each occupancy rejection costs +4.
//  - SPAWN_REQ while BUSY: ignored (not queued). SPAWN_REQ held high re-triggers from IDLE the cycle after DONE/FAIL.
//  - FOOD_EATEN clears FOOD_VALID in any state.
//    - With SPAWN_REQ in IDLE: cleared and spawn starts.
//    - In the same cycle as accept: accept wins, FOOD_VALID=1.
//  - Width rules: counters sized with $clog2(MAX_TRIES+1) and $clog2(GRID_W*GRID_H+1); no truncation of RND bits other than the low-bit slice.
//  - OCC_X/OCC_Y are held stable whenever OCC_QUERY=0 and are only meaningful when OCC_QUERY=1.
// STRUCTURE
//  - snake_pkg:
//    - GRID_W/GRID_H/XW/YW constants shared with the body tracker and renderer.
//    - spawn_state_t enum.
//  - Sub-module food_scan_counter: wrapping (x,y) cell counter with load, step and cells_checked / wrapped-full flag.
//  - FSM, candidate registers and output registers stay in food_spawner.
// TESTING
//  1. RND_X=5, RND_Y=7, OCC_HIT=0; pulse SPAWN_REQ
//     -> one RND_CE pulse, OCC query (5,7), SPAWN_DONE after edge 4, FOOD=(5,7), FOOD_VALID=1.
//  2. RND_X=50 (>=40) then 12, RND_Y=3
//     -> 2 RND_CE pulses, no query for x=50, FOOD=(12,3), done 2 cycles later than test 1.
//  3. Occupancy model hits (9,4) only; RND sequence gives (9,4) then (10,4)
//     -> 2 queries, FOOD=(10,4).
//  4. Every random candidate occupied, free cell only (0,0), last candidate (39,29)
//     -> 16 RND_CE pulses, then scan wraps (39,29)->(0,0), FOOD=(0,0).
//  5. All cells occupied
//     -> 16 random tries + 1200 scan queries, SPAWN_FAIL pulse, FOOD_VALID=0, BUSY=0 after.
//  6. Assert RESET in WAIT; separately, SPAWN_REQ while BUSY and FOOD_EATEN alone
//     -> RESET: all outputs 0, RND_CE=0, IDLE.
//     -> SPAWN_REQ while BUSY: ignored. FOOD_EATEN alone: clears FOOD_VALID.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: grid geometry shared by the snake blocks, plus the food spawner state encoding.
package snake_pkg;
   localparam int GRID_W    = 40;
   localparam int GRID_H    = 30;
   localparam int XW        = 6;
   localparam int YW        = 5;
   localparam int MAX_TRIES = 16;
   typedef enum logic [2:0] {
      S_IDLE, S_ADVANCE, S_SAMPLE, S_QUERY, S_WAIT, S_SCAN_Q, S_SCAN_W
   } spawn_state_t;
endpackage

// File: rtl/food_scan_counter.sv
// food_scan_counter: row-major wrapping cell walker used by the spawner's fallback scan.
module food_scan_counter #(
   parameter int GRID_W = snake_pkg::GRID_W,
   parameter int GRID_H = snake_pkg::GRID_H,
   parameter int XW     = snake_pkg::XW,
   parameter int YW     = snake_pkg::YW
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          i_load,
   input  logic [XW-1:0] i_ld_x,
   input  logic [YW-1:0] i_ld_y,
   input  logic          i_step,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_full
);
   localparam int NCELL = GRID_W * GRID_H;
   localparam int CW    = $clog2(NCELL + 1);
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [CW-1:0] r_cnt;
   logic          w_x_end;
   assign w_x_end = 32'(r_x) == GRID_W - 1;
   // The current cell is the last unvisited one once NCELL-1 cells have been stepped past.
   assign o_full  = r_cnt == CW'(NCELL - 1);
   assign o_x     = r_x;
   assign o_y     = r_y;
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         r_x   <= '0;
         r_y   <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_x   <= i_ld_x;
         r_y   <= i_ld_y;
         r_cnt <= '0;
      end else if (i_step) begin
         r_cnt <= r_cnt + CW'(1);
         r_x   <= w_x_end ? '0 : r_x + XW'(1);
         if (w_x_end) r_y <= 32'(r_y) == GRID_H - 1 ? '0 : r_y + YW'(1);
      end
endmodule

// File: rtl/food_spawner.sv
// food_spawner: places food on a free cell using random draws, then a deterministic
// linear scan once MAX_TRIES draws have been rejected.
module food_spawner #(
   parameter int GRID_W    = snake_pkg::GRID_W,
   parameter int GRID_H    = snake_pkg::GRID_H,
   parameter int XW        = snake_pkg::XW,
   parameter int YW        = snake_pkg::YW,
   parameter int MAX_TRIES = snake_pkg::MAX_TRIES
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          SPAWN_REQ,
   input  logic          FOOD_EATEN,
   input  logic [7:0]    RND_X,
   input  logic [7:0]    RND_Y,
   output logic          RND_CE,
   output logic          OCC_QUERY,
   output logic [XW-1:0] OCC_X,
   output logic [YW-1:0] OCC_Y,
   input  logic          OCC_HIT,
   output logic [XW-1:0] FOOD_X,
   output logic [YW-1:0] FOOD_Y,
   output logic          FOOD_VALID,
   output logic          BUSY,
   output logic          SPAWN_DONE,
   output logic          SPAWN_FAIL
);
   import snake_pkg::*;
   localparam int TW = $clog2(MAX_TRIES + 1);
   spawn_state_t  r_state, w_next;
   logic [TW-1:0] r_tries;
   logic [XW-1:0] r_cand_x, w_cx, w_scan_x;
   logic [YW-1:0] r_cand_y, w_cy, w_scan_y;
   logic          r_have_cand, r_scan_mode;
   logic          w_start, w_in_range, w_retry, w_reject, w_accept, w_fail, w_load, w_step, w_full;
   logic          w_unused;
   assign w_unused   = ^{RND_X, RND_Y};
   assign w_cx       = RND_X[XW-1:0];
   assign w_cy       = RND_Y[YW-1:0];
   assign w_in_range = 32'(w_cx) < GRID_W && 32'(w_cy) < GRID_H;
   assign w_retry    = 32'(r_tries) + 1 < MAX_TRIES;
   assign w_start    = r_state == S_IDLE && SPAWN_REQ;
   assign RND_CE     = r_state == S_ADVANCE;
   assign OCC_QUERY  = r_state == S_QUERY || r_state == S_SCAN_Q;
   assign BUSY       = r_state != S_IDLE;
   // Mode and both cell sources only change on edges that raise OCC_QUERY, keeping OCC_X/Y stable otherwise.
   assign OCC_X      = r_scan_mode ? w_scan_x : r_cand_x;
   assign OCC_Y      = r_scan_mode ? w_scan_y : r_cand_y;

   food_scan_counter #(.GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW)) u_scan (
      .CLK    (CLK),
      .RESET  (RESET),
      .i_load (w_load),
      .i_ld_x (r_have_cand ? r_cand_x : '0),
      .i_ld_y (r_have_cand ? r_cand_y : '0),
      .i_step (w_step),
      .o_x    (w_scan_x),
      .o_y    (w_scan_y),
      .o_full (w_full)
   );

   always_comb begin
      w_next   = r_state;
      w_reject = 1'b0;
      w_accept = 1'b0;
      w_fail   = 1'b0;
      w_step   = 1'b0;
      w_load   = 1'b0;
      case (r_state)
         S_IDLE:    w_next = SPAWN_REQ ? S_ADVANCE : S_IDLE;
         S_ADVANCE: w_next = S_SAMPLE;
         S_SAMPLE:  begin
            w_next   = S_QUERY;
            w_reject = !w_in_range;
         end
         S_QUERY:   w_next = S_WAIT;
         S_WAIT:    begin
            w_reject = OCC_HIT;
            w_accept = !OCC_HIT;
         end
         S_SCAN_Q:  w_next = S_SCAN_W;
         S_SCAN_W:  begin
            w_accept = !OCC_HIT;
            w_fail   = OCC_HIT && w_full;
            w_step   = OCC_HIT && !w_full;
            w_next   = S_SCAN_Q;
         end
         default:   w_next = S_IDLE;
      endcase
      if (w_reject) begin
         w_next = w_retry ? S_ADVANCE : S_SCAN_Q;
         w_load = !w_retry;
      end
      if (w_accept || w_fail) w_next = S_IDLE;
   end

   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         r_state     <= S_IDLE;
         r_tries     <= '0;
         r_cand_x    <= '0;
         r_cand_y    <= '0;
         r_have_cand <= 1'b0;
         r_scan_mode <= 1'b0;
         FOOD_X      <= '0;
         FOOD_Y      <= '0;
         FOOD_VALID  <= 1'b0;
         SPAWN_DONE  <= 1'b0;
         SPAWN_FAIL  <= 1'b0;
      end else begin
         r_state    <= w_next;
         SPAWN_DONE <= w_accept;
         SPAWN_FAIL <= w_fail;
         if (w_start) begin
            r_tries     <= '0;
            r_have_cand <= 1'b0;
         end else if (w_reject) r_tries <= r_tries + TW'(1);
         if (r_state == S_SAMPLE && w_in_range) begin
            r_cand_x    <= w_cx;
            r_cand_y    <= w_cy;
            r_have_cand <= 1'b1;
            r_scan_mode <= 1'b0;
         end
         if (w_load) r_scan_mode <= 1'b1;
         if (w_accept) begin
            FOOD_X     <= OCC_X;
            FOOD_Y     <= OCC_Y;
            FOOD_VALID <= 1'b1;
         end else if (FOOD_EATEN || w_start) FOOD_VALID <= 1'b0;
      end
endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner: scoreboard bench; stimulus queues expected spawn results, a monitor checks each DONE/FAIL.
module tb_food_spawner;
   logic       CLK = 0, RESET, SPAWN_REQ, FOOD_EATEN, OCC_HIT;
   logic [7:0] RND_X, RND_Y;
   logic       RND_CE, OCC_QUERY, FOOD_VALID, BUSY, SPAWN_DONE, SPAWN_FAIL;
   logic [5:0] OCC_X, FOOD_X;
   logic [4:0] OCC_Y, FOOD_Y;

   food_spawner dut (
      .CLK(CLK), .RESET(RESET), .SPAWN_REQ(SPAWN_REQ), .FOOD_EATEN(FOOD_EATEN),
      .RND_X(RND_X), .RND_Y(RND_Y), .RND_CE(RND_CE), .OCC_QUERY(OCC_QUERY),
      .OCC_X(OCC_X), .OCC_Y(OCC_Y), .OCC_HIT(OCC_HIT), .FOOD_X(FOOD_X), .FOOD_Y(FOOD_Y),
      .FOOD_VALID(FOOD_VALID), .BUSY(BUSY), .SPAWN_DONE(SPAWN_DONE), .SPAWN_FAIL(SPAWN_FAIL)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit fail;
      int fx, fy, v, lat, ce, nq, fq, lq;
   } exp_t;

   exp_t exp_q[$];
   int   rq_x[$], rq_y[$];
   int   n_tests = 0, n_fail = 0, ends = 0, mode = 0;
   int   ce_cnt = 0, q_cnt = 0, lat = 0, fq = 0, lq = 0;
   logic ce_s = 0, q_s = 0;
   int   qx_s = 0, qy_s = 0;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   function automatic exp_t mk(bit f, int fx, int fy, int v, int lt, int ce, int nq,
                               int fqx, int fqy, int lqx, int lqy);
      exp_t e;
      e.fail = f; e.fx = fx; e.fy = fy; e.v = v; e.lat = lt; e.ce = ce; e.nq = nq;
      e.fq = fqx * 256 + fqy; e.lq = lqx * 256 + lqy;
      return e;
   endfunction

   // 0: board empty, 1: only (9,4) taken, 2: all but (0,0) taken, 3: board full
   function automatic bit occ(int m, int x, int y);
      case (m)
         0:       return 1'b0;
         1:       return x == 9 && y == 4;
         2:       return !(x == 0 && y == 0);
         default: return 1'b1;
      endcase
   endfunction

   always @(negedge CLK) begin
      ce_s = RND_CE; q_s = OCC_QUERY; qx_s = int'(OCC_X); qy_s = int'(OCC_Y);
   end

   // Generator steps and occupancy answers appear just after the edge that consumes the request.
   always @(posedge CLK) begin
      #1;
      if (ce_s && rq_x.size() > 0) begin
         RND_X = 8'(rq_x.pop_front());
         RND_Y = 8'(rq_y.pop_front());
      end
      OCC_HIT = q_s && occ(mode, qx_s, qy_s);
   end

   always @(negedge CLK) begin
      exp_t e;
      if (RESET) begin
         ce_cnt = 0; q_cnt = 0; lat = 0;
      end else begin
         if (RND_CE) ce_cnt++;
         if (OCC_QUERY) begin
            lq = int'(OCC_X) * 256 + int'(OCC_Y);
            if (q_cnt == 0) fq = lq;
            q_cnt++;
         end
         if (BUSY) lat++;
         if (SPAWN_DONE || SPAWN_FAIL) begin
            if (exp_q.size() == 0) chk("unexpected_end", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("end_kind", {SPAWN_FAIL, SPAWN_DONE}, e.fail ? 2 : 1);
               chk("food_x", int'(FOOD_X), e.fx);
               chk("food_y", int'(FOOD_Y), e.fy);
               chk("food_valid", FOOD_VALID, e.v);
               chk("busy_at_end", BUSY, 0);
               chk("latency", lat, e.lat);
               chk("rnd_ce_pulses", ce_cnt, e.ce);
               chk("queries", q_cnt, e.nq);
               chk("first_query", fq, e.fq);
               chk("last_query", lq, e.lq);
            end
            ce_cnt = 0; q_cnt = 0; lat = 0;
            ends++;
         end
      end
   end

   task automatic rnd(input int x, input int y);
      rq_x.push_back(x);
      rq_y.push_back(y);
   endtask

   task automatic pulse();
      @(posedge CLK); #1 SPAWN_REQ = 1;
      @(posedge CLK); #1 SPAWN_REQ = 0;
   endtask

   task automatic wait_done(input int n0);
      int k = 0;
      while (ends == n0 && k < 4000) begin
         @(posedge CLK);
         k++;
      end
      #1;
      if (ends == n0) chk("spawn_timeout", 0, 1);
   endtask

   task automatic spawn(input exp_t e);
      int n0 = ends;
      exp_q.push_back(e);
      pulse();
      wait_done(n0);
   endtask

   task automatic fill16();
      for (int i = 0; i < 15; i++) rnd(i + 1, i + 1);
      rnd(39, 29);
   endtask

   initial begin
      int n0;
      RESET = 1; SPAWN_REQ = 0; FOOD_EATEN = 0; RND_X = 0; RND_Y = 0; OCC_HIT = 0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_busy", BUSY, 0);
      chk("rst_rnd_ce", RND_CE, 0);
      chk("rst_valid", FOOD_VALID, 0);
      chk("rst_food", int'(FOOD_X) + int'(FOOD_Y), 0);
      RESET = 0;

      mode = 0;
      rnd(5, 7);         spawn(mk(0, 5, 7, 1, 4, 1, 1, 5, 7, 5, 7));
      rnd(8'h4A, 8'hE3); spawn(mk(0, 10, 3, 1, 4, 1, 1, 10, 3, 10, 3));
      rnd(50, 3); rnd(12, 3); spawn(mk(0, 12, 3, 1, 6, 2, 1, 12, 3, 12, 3));
      rnd(4, 30); rnd(7, 2);  spawn(mk(0, 7, 2, 1, 6, 2, 1, 7, 2, 7, 2));
      rnd(40, 5); rnd(0, 29); spawn(mk(0, 0, 29, 1, 6, 2, 1, 0, 29, 0, 29));
      mode = 1;
      rnd(9, 4); rnd(10, 4);  spawn(mk(0, 10, 4, 1, 8, 2, 2, 9, 4, 10, 4));
      mode = 3;
      fill16();               spawn(mk(1, 10, 4, 0, 2464, 16, 1216, 1, 1, 38, 29));
      mode = 2;
      fill16();               spawn(mk(0, 0, 0, 1, 68, 16, 18, 1, 1, 0, 0));

      mode = 0;
      FOOD_EATEN = 1;
      rnd(6, 8);              spawn(mk(0, 6, 8, 1, 4, 1, 1, 6, 8, 6, 8));
      FOOD_EATEN = 0;
      chk("eaten_after_done", FOOD_VALID, 0);

      rnd(3, 3);
      exp_q.push_back(mk(0, 3, 3, 1, 4, 1, 1, 3, 3, 3, 3));
      n0 = ends;
      pulse();
      SPAWN_REQ = 1;
      @(posedge CLK); #1 SPAWN_REQ = 0;
      wait_done(n0);
      repeat (8) @(posedge CLK);
      #1;
      chk("busy_req_ignored", ends, n0 + 1);
      chk("busy_after_ignore", BUSY, 0);

      @(posedge CLK); #1 FOOD_EATEN = 1;
      @(posedge CLK); #1 FOOD_EATEN = 0;
      chk("eaten_alone_valid", FOOD_VALID, 0);
      chk("eaten_alone_food", int'(FOOD_X) * 256 + int'(FOOD_Y), 3 * 256 + 3);

      rnd(20, 20);
      n0 = ends;
      pulse();
      repeat (3) @(posedge CLK);
      #2;
      chk("pre_rst_busy", BUSY, 1);
      chk("pre_rst_wait_no_query", OCC_QUERY, 0);
      RESET = 1;
      #1;
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_rnd_ce", RND_CE, 0);
      chk("mid_rst_query", OCC_QUERY, 0);
      chk("mid_rst_occ", int'(OCC_X) + int'(OCC_Y), 0);
      chk("mid_rst_food", int'(FOOD_X) + int'(FOOD_Y), 0);
      chk("mid_rst_flags", int'({FOOD_VALID, SPAWN_DONE, SPAWN_FAIL}), 0);
      @(posedge CLK); #1 RESET = 0;
      repeat (10) @(posedge CLK);
      #1;
      chk("rst_abort_no_end", ends, n0);
      chk("rst_abort_idle", BUSY, 0);
      rq_x.delete(); rq_y.delete();
      rnd(7, 9);              spawn(mk(0, 7, 9, 1, 4, 1, 1, 7, 9, 7, 9));
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
